pipelined_controller: RTL and testbench
=======================================

PIPELINED_CONTROLLER -- requirements
Module: pipelined_controller

Interface
REQ-001 SHALL have parameter STAGES, default 1, count of control pipeline registers between decode and *_ppl outputs (legal 1..4).
REQ-002 SHALL have parameter GEMM_EN, default 1, 1 = GEMM opcode decoded and GEMM issue FSM enabled.
REQ-003 SHALL have parameter GEMM_TIMEOUT, default 1024, max WAIT cycles before abort (0 = no timeout).
REQ-004 SHALL have one clock and a synchronous active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-005 Port: instruction  in  32  instruction being decoded.
REQ-006 Port: instr_valid  in  1  instruction is real; 0 injects a bubble.
REQ-007 Port: stall  in  1  external hazard stall, holds all stages.
REQ-008 Port: flush  in  STAGES  per-stage flush, bit i clears stage i.
REQ-009 Port: br_taken  in  1  branch comparator result.
REQ-010 Port: gemm_done  in  1  GEMM engine completion pulse.
REQ-011 Port: alu_ctrl  out  4  combinational ALU opcode for the decoded instruction.
REQ-012 Port: a_sel, b_sel  out  1 each  combinational operand selects.
REQ-013 Port: reg_wr_ppl, mem_wr_ppl, mem_read_ppl, pc_sel_ppl, is_mret_ppl, csr_reg_r_ppl, csr_reg_wr_ppl, is_gemm_ppl, illegal_ppl  out  1 each  pipelined controls.
REQ-014 Port: wb_sel_ppl  out  2  pipelined writeback select (00 PC+4, 01 ALU, 10 load, 11 CSR).
REQ-015 Port: gemm_start  out  1  one-cycle GEMM launch pulse.
REQ-016 Port: gemm_busy  out  1  high while FSM is in WAIT.
REQ-017 Port: gemm_timeout  out  1  one-cycle abort pulse.
REQ-018 Port: stall_req  out  1  controller-generated front-end stall.

Function
REQ-019 Decode on opcode[6:2]: R 01100, I 00100, load 00000, store 01000, branch 11000, jal 11011, jalr 11001, lui 01101, auipc 00101, system 11100, GEMM 00010; ALU codes ADD0 SUB1 SLL2 SLT3 XOR4 SLTU5 SRL6 SRA7 OR8 AND9 LUI10; SUB/SRA select via instruction[30].
REQ-020 Branch pc_sel = br_taken; jal/jalr pc_sel = 1; system: instruction[29]=1 with func3 000 gives is_mret, func3 001 gives csr_reg_r = csr_reg_wr = 1.
REQ-021 Unknown opcode, or GEMM opcode with GEMM_EN=0: illegal=1, all other controls 0, alu_ctrl=0; decode outputs SHALL never be X.
REQ-022 instr_valid=0: stage-0 input is all-zero bundle (bubble).
REQ-023 Stage update priority per stage i: rst > flush[i] (load zeros) > (stall | stall_req) (hold) > load from stage i-1 (stage 0 from decode).
REQ-024 Latency: with no stall/flush, controls decoded at cycle t appear on *_ppl at t+STAGES.
REQ-025 FSM states IDLE, WAIT; IDLE -> WAIT when is_gemm_ppl=1; that cycle gemm_start=1 and timeout counter loads 0.
REQ-026 WAIT: stall_req=1, gemm_busy=1, counter +1 per cycle; gemm_done -> IDLE and last-stage is_gemm bit cleared next edge.
REQ-027 WAIT with counter = GEMM_TIMEOUT-1 and no gemm_done: gemm_timeout=1 for one cycle, -> IDLE, last-stage is_gemm cleared; gemm_done same cycle wins, no timeout pulse.
REQ-028 flush during WAIT clears stages but SHALL NOT leave WAIT; only gemm_done or timeout exit.
REQ-029 Cleared is_gemm SHALL prevent a second gemm_start for the same instruction, even if stall holds the last stage.

Reset
REQ-030 rst SHALL, at the next edge, zero every pipeline stage (all *_ppl = 0), force IDLE, zero counter; gemm_start, gemm_busy, gemm_timeout, stall_req = 0, including mid-WAIT.

Verification
REQ-031 STAGES=2, add x1,x2,x3 (0x003100B3) valid -> alu_ctrl=0 same cycle; reg_wr_ppl=1, wb_sel_ppl=01 exactly 2 cycles later.
REQ-032 Opcode 0x7F valid -> illegal_ppl=1, reg_wr/mem_wr/pc_sel_ppl=0, no X on any output.
REQ-033 GEMM instr, gemm_done 5 cycles after gemm_start -> single gemm_start pulse, stall_req high 5 cycles, is_gemm_ppl=0 after exit.
REQ-034 GEMM_TIMEOUT=8, no gemm_done -> gemm_timeout pulse on 8th WAIT cycle, return to IDLE; done on that same cycle -> no pulse.
REQ-035 rst asserted during WAIT with stall=1 -> next cycle all outputs 0, FSM IDLE; flush[STAGES-1] in WAIT -> gemm_busy stays 1.

Source files
------------

// File: rtl/pipelined_controller.sv
// Instruction decoder with a STAGES-deep control pipeline and a GEMM issue FSM
// that stalls the pipeline while an external GEMM engine is running.
module pipelined_controller #(
    parameter int unsigned STAGES       = 1,
    parameter int unsigned GEMM_EN      = 1,
    parameter int unsigned GEMM_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instruction,
    input  logic              instr_valid,
    input  logic              stall,
    input  logic [STAGES-1:0] flush,
    input  logic              br_taken,
    input  logic              gemm_done,
    output logic [3:0]        alu_ctrl,
    output logic              a_sel,
    output logic              b_sel,
    output logic              reg_wr_ppl,
    output logic              mem_wr_ppl,
    output logic              mem_read_ppl,
    output logic              pc_sel_ppl,
    output logic              is_mret_ppl,
    output logic              csr_reg_r_ppl,
    output logic              csr_reg_wr_ppl,
    output logic              is_gemm_ppl,
    output logic              illegal_ppl,
    output logic [1:0]        wb_sel_ppl,
    output logic              gemm_start,
    output logic              gemm_busy,
    output logic              gemm_timeout,
    output logic              stall_req
);

    localparam int unsigned CNT_W = (GEMM_TIMEOUT > 1) ? $clog2(GEMM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GEMM_TIMEOUT - 1);
    localparam int unsigned LAST = STAGES - 1;

    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_I      = 5'b00100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;
    localparam logic [4:0] OP_GEMM   = 5'b00010;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLTU = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_LUI  = 4'd10;

    typedef struct packed {
        logic       reg_wr;
        logic       mem_wr;
        logic       mem_read;
        logic       pc_sel;
        logic       is_mret;
        logic       csr_reg_r;
        logic       csr_reg_wr;
        logic       is_gemm;
        logic       illegal;
        logic [1:0] wb_sel;
    } ctrl_t;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    logic [4:0] opcode;
    logic [2:0] func3;
    logic       alt;
    ctrl_t      dec;

    ctrl_t            stage_q [STAGES];
    ctrl_t            stage_d [STAGES];
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gemm_exit;
    logic             hold;

    logic unused_instr_bits;

    assign opcode = instruction[6:2];
    assign func3  = instruction[14:12];
    assign alt    = instruction[30];
    assign unused_instr_bits = ^{instruction[31], instruction[28:15],
                                 instruction[11:7], instruction[1:0]};

    // ALU operation from func3; SUB only exists for register-register ops
    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt_bit,
                                               input logic is_reg);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (alt_bit && is_reg) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt_bit ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Combinational decode; a_sel=1 picks PC, b_sel=1 picks the immediate
    always_comb begin
        dec      = '0;
        alu_ctrl = ALU_ADD;
        a_sel    = 1'b0;
        b_sel    = 1'b0;
        case (opcode)
            OP_R: begin
                dec.reg_wr = 1'b1;
                dec.wb_sel = 2'b01;
                alu_ctrl   = alu_from_f3(func3, alt, 1'b1);
            end
            OP_I: begin
                dec.reg_wr = 1'b1;
                dec.wb_sel = 2'b01;
                alu_ctrl   = alu_from_f3(func3, alt, 1'b0);
                b_sel      = 1'b1;
            end
            OP_LOAD: begin
                dec.reg_wr   = 1'b1;
                dec.mem_read = 1'b1;
                dec.wb_sel   = 2'b10;
                b_sel        = 1'b1;
            end
            OP_STORE: begin
                dec.mem_wr = 1'b1;
                b_sel      = 1'b1;
            end
            OP_BRANCH: begin
                dec.pc_sel = br_taken;
                a_sel      = 1'b1;
                b_sel      = 1'b1;
            end
            OP_JAL: begin
                dec.reg_wr = 1'b1;
                dec.pc_sel = 1'b1;
                a_sel      = 1'b1;
                b_sel      = 1'b1;
            end
            OP_JALR: begin
                dec.reg_wr = 1'b1;
                dec.pc_sel = 1'b1;
                b_sel      = 1'b1;
            end
            OP_LUI: begin
                dec.reg_wr = 1'b1;
                dec.wb_sel = 2'b01;
                alu_ctrl   = ALU_LUI;
                b_sel      = 1'b1;
            end
            OP_AUIPC: begin
                dec.reg_wr = 1'b1;
                dec.wb_sel = 2'b01;
                a_sel      = 1'b1;
                b_sel      = 1'b1;
            end
            OP_SYSTEM: begin
                if (func3 == 3'b000 && instruction[29]) begin
                    dec.is_mret = 1'b1;
                end else if (func3 == 3'b001) begin
                    dec.csr_reg_r  = 1'b1;
                    dec.csr_reg_wr = 1'b1;
                    dec.reg_wr     = 1'b1;
                    dec.wb_sel     = 2'b11;
                end
            end
            OP_GEMM: begin
                if (GEMM_EN != 0) begin
                    dec.is_gemm = 1'b1;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // GEMM issue FSM: launch from the last stage, hold the pipe until done or timeout
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        gemm_start   = 1'b0;
        gemm_timeout = 1'b0;
        gemm_exit    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (GEMM_EN != 0 && stage_q[LAST].is_gemm) begin
                    gemm_start = 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (gemm_done) begin
                    gemm_exit = 1'b1;
                    state_d   = ST_IDLE;
                end else if (GEMM_TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    gemm_timeout = 1'b1;
                    gemm_exit    = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign gemm_busy = (state_q == ST_WAIT);
    assign stall_req = (state_q == ST_WAIT);
    assign hold      = stall | stall_req;

    // Per-stage update: flush beats hold beats advance
    always_comb begin
        stage_d = stage_q;
        if (flush[0]) begin
            stage_d[0] = '0;
        end else if (!hold) begin
            stage_d[0] = instr_valid ? dec : '0;
        end
        for (int i = 1; i < int'(STAGES); i++) begin
            if (flush[i]) begin
                stage_d[i] = '0;
            end else if (!hold) begin
                stage_d[i] = stage_q[i-1];
            end
        end
        // Retire the issued GEMM so a held last stage cannot relaunch it
        if (gemm_exit) begin
            stage_d[LAST].is_gemm = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            for (int i = 0; i < int'(STAGES); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < int'(STAGES); i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign reg_wr_ppl     = stage_q[LAST].reg_wr;
    assign mem_wr_ppl     = stage_q[LAST].mem_wr;
    assign mem_read_ppl   = stage_q[LAST].mem_read;
    assign pc_sel_ppl     = stage_q[LAST].pc_sel;
    assign is_mret_ppl    = stage_q[LAST].is_mret;
    assign csr_reg_r_ppl  = stage_q[LAST].csr_reg_r;
    assign csr_reg_wr_ppl = stage_q[LAST].csr_reg_wr;
    assign is_gemm_ppl    = stage_q[LAST].is_gemm;
    assign illegal_ppl    = stage_q[LAST].illegal;
    assign wb_sel_ppl     = stage_q[LAST].wb_sel;

endmodule

// File: tb/tb_pipelined_controller.sv
// Scoreboard bench for pipelined_controller (STAGES=2, GEMM_TIMEOUT=8).
module tb_pipelined_controller;

    localparam int unsigned STAGES = 2;
    localparam int unsigned GTO    = 8;
    localparam logic [31:0] GEMM_INS = 32'h0000_000B;
    localparam logic [31:0] ADD_INS  = 32'h0031_00B3;

    // expected bundle bit positions; wb_sel in [1:0]
    localparam int B_REG_WR = 10, B_MEM_WR = 9, B_MEM_RD = 8, B_PC_SEL = 7, B_MRET = 6;
    localparam int B_CSR_R = 5, B_CSR_W = 4, B_GEMM = 3, B_ILL = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       instruction;
    logic              instr_valid;
    logic              stall;
    logic [STAGES-1:0] flush;
    logic              br_taken;
    logic              gemm_done;
    logic [3:0]        alu_ctrl;
    logic              a_sel, b_sel;
    logic              reg_wr_ppl, mem_wr_ppl, mem_read_ppl, pc_sel_ppl, is_mret_ppl;
    logic              csr_reg_r_ppl, csr_reg_wr_ppl, is_gemm_ppl, illegal_ppl;
    logic [1:0]        wb_sel_ppl;
    logic              gemm_start, gemm_busy, gemm_timeout, stall_req;

    int n_cmp = 0;
    int n_err = 0;
    logic [10:0] sb[$];

    pipelined_controller #(.STAGES(STAGES), .GEMM_EN(1), .GEMM_TIMEOUT(GTO)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
        .stall(stall), .flush(flush), .br_taken(br_taken), .gemm_done(gemm_done),
        .alu_ctrl(alu_ctrl), .a_sel(a_sel), .b_sel(b_sel),
        .reg_wr_ppl(reg_wr_ppl), .mem_wr_ppl(mem_wr_ppl), .mem_read_ppl(mem_read_ppl),
        .pc_sel_ppl(pc_sel_ppl), .is_mret_ppl(is_mret_ppl), .csr_reg_r_ppl(csr_reg_r_ppl),
        .csr_reg_wr_ppl(csr_reg_wr_ppl), .is_gemm_ppl(is_gemm_ppl), .illegal_ppl(illegal_ppl),
        .wb_sel_ppl(wb_sel_ppl), .gemm_start(gemm_start), .gemm_busy(gemm_busy),
        .gemm_timeout(gemm_timeout), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [10:0] ppl_obs();
        return {reg_wr_ppl, mem_wr_ppl, mem_read_ppl, pc_sel_ppl, is_mret_ppl, csr_reg_r_ppl,
                csr_reg_wr_ppl, is_gemm_ppl, illegal_ppl, wb_sel_ppl};
    endfunction

    // Reference decode written from the opcode/ALU tables
    task automatic model_dec(input logic [31:0] ins, input logic bt, output logic [10:0] b,
                             output logic [3:0] alu, output logic as, output logic bs);
        logic [3:0] tbl [8];
        logic [4:0] op;
        logic [2:0] f3;
        tbl = '{4'd0, 4'd2, 4'd3, 4'd5, 4'd4, 4'd6, 4'd8, 4'd9};
        op  = ins[6:2];
        f3  = ins[14:12];
        b = '0; alu = 4'd0; as = 1'b0; bs = 1'b0;
        case (op)
            5'b01100: begin
                b[B_REG_WR] = 1'b1; b[1:0] = 2'b01; alu = tbl[f3];
                if (f3 == 3'd0 && ins[30]) alu = 4'd1;
                if (f3 == 3'd5 && ins[30]) alu = 4'd7;
            end
            5'b00100: begin
                b[B_REG_WR] = 1'b1; b[1:0] = 2'b01; alu = tbl[f3]; bs = 1'b1;
                if (f3 == 3'd5 && ins[30]) alu = 4'd7;
            end
            5'b00000: begin b[B_REG_WR] = 1'b1; b[B_MEM_RD] = 1'b1; b[1:0] = 2'b10; bs = 1'b1; end
            5'b01000: begin b[B_MEM_WR] = 1'b1; bs = 1'b1; end
            5'b11000: begin b[B_PC_SEL] = bt; as = 1'b1; bs = 1'b1; end
            5'b11011: begin b[B_REG_WR] = 1'b1; b[B_PC_SEL] = 1'b1; as = 1'b1; bs = 1'b1; end
            5'b11001: begin b[B_REG_WR] = 1'b1; b[B_PC_SEL] = 1'b1; bs = 1'b1; end
            5'b01101: begin b[B_REG_WR] = 1'b1; b[1:0] = 2'b01; alu = 4'd10; bs = 1'b1; end
            5'b00101: begin b[B_REG_WR] = 1'b1; b[1:0] = 2'b01; as = 1'b1; bs = 1'b1; end
            5'b11100: begin
                if (f3 == 3'd0 && ins[29]) b[B_MRET] = 1'b1;
                else if (f3 == 3'd1) begin
                    b[B_CSR_R] = 1'b1; b[B_CSR_W] = 1'b1; b[B_REG_WR] = 1'b1; b[1:0] = 2'b11;
                end
            end
            5'b00010: b[B_GEMM] = 1'b1;
            default:  b[B_ILL] = 1'b1;
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; instruction = '0; instr_valid = 1'b0; stall = 1'b0;
        flush = '0; br_taken = 1'b0; gemm_done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        for (int i = 0; i < int'(STAGES); i++) sb.push_back('0);
    endtask

    // Drive one decode per cycle; compare the pipe output against the queued expectation
    task automatic run_stream(input int n_rand);
        logic [31:0] dir_ins [15];
        logic        dir_bt  [15];
        logic [31:0] ins;
        logic        v, bt, as, bs;
        logic [10:0] eb, got_exp;
        logic [3:0]  ealu;
        int          total;
        dir_ins = '{ADD_INS, 32'h0000_007F, 32'h4031_0133, 32'h1234_50B7, 32'h0000_A083,
                    32'h0011_2023, 32'h0020_8463, 32'h0020_8463, 32'h0080_00EF, 32'h0000_80E7,
                    32'h0000_0097, 32'h3020_0073, 32'h3402_9073, 32'h4030_D093, ADD_INS};
        dir_bt  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        total = 15 + n_rand;
        for (int c = 0; c < total + int'(STAGES); c++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                check_val("sb_empty", 32'(1), 32'(0));
            end else begin
                got_exp = sb.pop_front();
                check_val("ppl", 32'(ppl_obs()), 32'(got_exp));
            end
            if (c < total) begin
                if (c < 15) begin
                    ins = dir_ins[c]; bt = dir_bt[c]; v = (c != 14);
                end else begin
                    ins = $urandom();
                    if (ins[6:2] == 5'b00010) ins[6:2] = 5'b11111;
                    bt = 1'($urandom_range(0, 1));
                    v  = ($urandom_range(0, 3) != 0);
                end
                instruction = ins; br_taken = bt; instr_valid = v;
                #1;
                model_dec(ins, bt, eb, ealu, as, bs);
                check_val("alu_ctrl", 32'(alu_ctrl), 32'(ealu));
                check_val("a_b_sel", 32'({a_sel, b_sel}), 32'({as, bs}));
                check_val("nox", 32'($isunknown({alu_ctrl, a_sel, b_sel, ppl_obs(), gemm_start,
                          gemm_busy, gemm_timeout, stall_req})), 32'(0));
                sb.push_back(v ? eb : 11'd0);
            end else begin
                instr_valid = 1'b0;
            end
        end
    endtask

    // Issue one GEMM and watch the handshake for 20 cycles
    task automatic gemm_run(input int done_off, input bit hold_ext, output int n_start,
                            output int n_stall, output int n_to, output int start_at,
                            output int to_at);
        n_start = 0; n_stall = 0; n_to = 0; start_at = -1; to_at = -1;
        @(negedge clk);
        instruction = GEMM_INS; instr_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            instruction = '0; instr_valid = 1'b0;
            gemm_done = (start_at >= 0 && done_off >= 0 && c == start_at + done_off);
            stall = hold_ext && (c >= 1);
            #1;
            if (gemm_start) begin
                n_start++;
                if (start_at < 0) start_at = c;
            end
            if (stall_req) n_stall++;
            if (gemm_timeout) begin
                n_to++;
                to_at = c;
            end
        end
        gemm_done = 1'b0;
    endtask

    initial begin
        int ns, nst, nto, sa, ta;
        logic [10:0] add_b;
        logic [3:0]  dalu;
        logic        das, dbs;
        rst = 1'b1; instruction = '0; instr_valid = 1'b0; stall = 1'b0;
        flush = '0; br_taken = 1'b0; gemm_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("rst_ppl", 32'(ppl_obs()), 32'(0));
        check_val("rst_fsm", 32'({gemm_start, gemm_busy, gemm_timeout, stall_req}), 32'(0));
        rst = 1'b0;

        do_reset();
        run_stream(40);

        // external stall holds, then flush beats stall
        model_dec(ADD_INS, 1'b0, add_b, dalu, das, dbs);
        do_reset();
        instruction = ADD_INS; instr_valid = 1'b1;
        @(negedge clk); instr_valid = 1'b0; stall = 1'b1;
        @(negedge clk); check_val("stall_hold0", 32'(ppl_obs()), 32'(0));
        @(negedge clk); check_val("stall_hold1", 32'(ppl_obs()), 32'(0)); stall = 1'b0;
        @(negedge clk); check_val("stall_release", 32'(ppl_obs()), 32'(add_b));
        instruction = ADD_INS; instr_valid = 1'b1;
        @(negedge clk); check_val("after_release", 32'(ppl_obs()), 32'(0));
        instr_valid = 1'b0; stall = 1'b1; flush = 2'b01;
        @(negedge clk); flush = '0; stall = 1'b0;
        @(negedge clk); check_val("flush_over_stall", 32'(ppl_obs()), 32'(0));

        do_reset();
        gemm_run(5, 1'b0, ns, nst, nto, sa, ta);
        check_val("done_starts", 32'(ns), 32'(1));
        check_val("done_stall_cycles", 32'(nst), 32'(5));
        check_val("done_no_timeout", 32'(nto), 32'(0));
        check_val("done_exit", 32'({gemm_busy, stall_req, is_gemm_ppl}), 32'(0));

        do_reset();
        gemm_run(-1, 1'b0, ns, nst, nto, sa, ta);
        check_val("to_starts", 32'(ns), 32'(1));
        check_val("to_pulses", 32'(nto), 32'(1));
        check_val("to_cycle", 32'(ta - sa), 32'(GTO));
        check_val("to_stall_cycles", 32'(nst), 32'(GTO));
        check_val("to_exit", 32'({gemm_busy, stall_req}), 32'(0));

        do_reset();
        gemm_run(int'(GTO), 1'b0, ns, nst, nto, sa, ta);
        check_val("done_wins_pulses", 32'(nto), 32'(0));
        check_val("done_wins_stall", 32'(nst), 32'(GTO));
        check_val("done_wins_exit", 32'(gemm_busy), 32'(0));

        do_reset();
        gemm_run(5, 1'b1, ns, nst, nto, sa, ta);
        check_val("held_starts", 32'(ns), 32'(1));
        check_val("held_is_gemm", 32'(is_gemm_ppl), 32'(0));
        check_val("held_busy", 32'(gemm_busy), 32'(0));
        stall = 1'b0;

        // reset in WAIT with the GEMM held in the last stage
        do_reset();
        instruction = GEMM_INS; instr_valid = 1'b1;
        @(negedge clk); instr_valid = 1'b0; instruction = '0;
        @(negedge clk); check_val("rw_start", 32'(gemm_start), 32'(1)); stall = 1'b1;
        @(negedge clk); check_val("rw_wait", 32'({gemm_busy, is_gemm_ppl}), 32'(3)); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check_val("rw_ppl", 32'(ppl_obs()), 32'(0));
        check_val("rw_fsm", 32'({gemm_start, gemm_busy, gemm_timeout, stall_req}), 32'(0));
        stall = 1'b0;

        // flush in WAIT clears stages but keeps waiting
        do_reset();
        instruction = GEMM_INS; instr_valid = 1'b1;
        @(negedge clk); instr_valid = 1'b0; instruction = '0;
        @(negedge clk); stall = 1'b1;
        @(negedge clk); stall = 1'b0; flush = 2'b10;
        @(negedge clk); flush = '0;
        check_val("fl_busy", 32'({gemm_busy, stall_req}), 32'(3));
        check_val("fl_cleared", 32'(is_gemm_ppl), 32'(0));
        @(negedge clk);
        @(negedge clk); check_val("fl_still_busy", 32'(gemm_busy), 32'(1)); gemm_done = 1'b1;
        @(negedge clk); gemm_done = 1'b0;
        check_val("fl_exit", 32'({gemm_busy, gemm_start}), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
